// File: rtl/memory_access_ext.sv
// MEM stage: byte/half/word loads and stores with extension, byte enables and
// misalignment detection, a req/ack data-memory handshake that stalls upstream
// while an access is outstanding, and a registered pipeline boundary.
module memory_access_ext #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int DATA_MEM_WIDTH = 3
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      RegWrite,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                Branch,
  input  logic [1:0]                mem_size,
  input  logic                      mem_unsigned,
  input  logic [31:0]               register_data,
  input  logic [31:0]               alu_result,
  input  logic [4:0]                rdist,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic [INST_MEM_WIDTH-1:0] pc2,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_MEM_WIDTH-1:0] dmem_addr,
  output logic [31:0]               dmem_wdata,
  output logic [3:0]                dmem_be,
  input  logic                      dmem_ack,
  input  logic [31:0]               dmem_rdata,
  output logic                      out_valid,
  output logic                      RegWrite_next,
  output logic                      UARTtoReg_next,
  output logic [1:0]                MemtoReg_next,
  output logic [1:0]                Branch_next,
  output logic [31:0]               read_data,
  output logic [31:0]               register_data_next,
  output logic [31:0]               alu_result_next,
  output logic [4:0]                rdist_next,
  output logic [25:0]               inst_index_next,
  output logic [INST_MEM_WIDTH-1:0] pc_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic [INST_MEM_WIDTH-1:0] pc2_next,
  output logic                      misalign
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Fields carried unchanged (apart from RegWrite squashing) to write-back.
  typedef struct packed {
    logic                      regwrite;
    logic                      uart;
    logic [1:0]                memtoreg;
    logic [1:0]                branch;
    logic [31:0]               register_data;
    logic [31:0]               alu_result;
    logic [4:0]                rdist;
    logic [25:0]               inst_index;
    logic [INST_MEM_WIDTH-1:0] pc;
    logic [INST_MEM_WIDTH-1:0] pc1;
    logic [INST_MEM_WIDTH-1:0] pc2;
  } fields_t;

  state_t      state;
  fields_t     in_f;
  fields_t     pend;
  fields_t     nxt;
  logic        p_load;
  logic [1:0]  p_size;
  logic        p_unsigned;
  logic [1:0]  p_lane;
  logic [1:0]  lane;
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  assign in_ready           = (state == S_IDLE) && reset;
  assign RegWrite_next      = nxt.regwrite;
  assign UARTtoReg_next     = nxt.uart;
  assign MemtoReg_next      = nxt.memtoreg;
  assign Branch_next        = nxt.branch;
  assign register_data_next = nxt.register_data;
  assign alu_result_next    = nxt.alu_result;
  assign rdist_next         = nxt.rdist;
  assign inst_index_next    = nxt.inst_index;
  assign pc_next            = nxt.pc;
  assign pc1_next           = nxt.pc1;
  assign pc2_next           = nxt.pc2;

  // Select and extend the addressed byte/half of the returned word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  ln);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*ln +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Decode the incoming access: alignment, byte enables and replicated store data.
  always_comb begin
    lane       = alu_result[1:0];
    is_mem     = MemRead | MemWrite;
    misaligned = 1'b0;
    be_c       = 4'hF;
    wdata_c    = register_data;
    case (mem_size)
      2'b00: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{register_data[7:0]}};
      end
      2'b01: begin
        misaligned = is_mem & lane[0];
        be_c       = 4'b0011 << {lane[1], 1'b0};
        wdata_c    = {2{register_data[15:0]}};
      end
      default: misaligned = is_mem & (lane != 2'b00);
    endcase
    in_f = {RegWrite, UARTtoReg, MemtoReg, Branch, register_data, alu_result,
            rdist, inst_index, pc, pc1, pc2};
    if (misaligned) in_f.regwrite = 1'b0;
  end

  // Stage FSM: accept in IDLE, hold a registered request in WAIT until ack.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pend       <= '0;
      nxt        <= '0;
      p_load     <= 1'b0;
      p_size     <= 2'b00;
      p_unsigned <= 1'b0;
      p_lane     <= 2'b00;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      out_valid  <= 1'b0;
      misalign   <= 1'b0;
      read_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      misalign  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (!is_mem || misaligned) begin
              nxt       <= in_f;
              read_data <= '0;
              misalign  <= misaligned;
              out_valid <= 1'b1;
            end else begin
              pend       <= in_f;
              p_load     <= MemRead & ~MemWrite;
              p_size     <= mem_size;
              p_unsigned <= mem_unsigned;
              p_lane     <= lane;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite;
              dmem_addr  <= alu_result[DATA_MEM_WIDTH+1:2];
              dmem_wdata <= wdata_c;
              dmem_be    <= be_c;
              state      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            nxt       <= pend;
            read_data <= p_load ? load_extend(dmem_rdata, p_size, p_unsigned, p_lane) : '0;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_ext.sv
// Directed bench for memory_access_ext with a scoreboard of expected write-back fields.
module tb_memory_access_ext;
  localparam int IW = 2;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rstN;
  logic          inValid, inReady;
  logic          regWrite, memWrite, memRead, uartToReg;
  logic [1:0]    memToReg, branch, memSize;
  logic          memUnsigned;
  logic [31:0]   registerData, aluResult;
  logic [4:0]    rdist;
  logic [25:0]   instIndex;
  logic [IW-1:0] pc, pc1, pc2;
  logic          dmemReq, dmemWe, dmemAck;
  logic [DW-1:0] dmemAddr;
  logic [31:0]   dmemWdata, dmemRdata;
  logic [3:0]    dmemBe;
  logic          outValid, regWriteNext, uartToRegNext, misalign;
  logic [1:0]    memToRegNext, branchNext;
  logic [31:0]   readData, registerDataNext, aluResultNext;
  logic [4:0]    rdistNext;
  logic [25:0]   instIndexNext;
  logic [IW-1:0] pcNext, pc1Next, pc2Next;

  typedef struct {
    logic [31:0]   aluResult;
    logic [31:0]   readData;
    logic [31:0]   regData;
    logic          regWrite;
    logic          uartToReg;
    logic          misalign;
    logic [1:0]    memToReg;
    logic [1:0]    branch;
    logic [4:0]    rdist;
    logic [25:0]   instIndex;
    logic [IW-1:0] pc;
    logic [IW-1:0] pc1;
    logic [IW-1:0] pc2;
  } expect_t;

  expect_t scoreboard[$];
  int testsRun = 0;
  int testsFailed = 0;
  int txnId = 0;

  memory_access_ext #(.INST_MEM_WIDTH(IW), .DATA_MEM_WIDTH(DW)) dut (
    .CLK(clk), .reset(rstN), .in_valid(inValid), .in_ready(inReady),
    .RegWrite(regWrite), .MemWrite(memWrite), .MemRead(memRead), .UARTtoReg(uartToReg),
    .MemtoReg(memToReg), .Branch(branch), .mem_size(memSize), .mem_unsigned(memUnsigned),
    .register_data(registerData), .alu_result(aluResult), .rdist(rdist),
    .inst_index(instIndex), .pc(pc), .pc1(pc1), .pc2(pc2),
    .dmem_req(dmemReq), .dmem_we(dmemWe), .dmem_addr(dmemAddr), .dmem_wdata(dmemWdata),
    .dmem_be(dmemBe), .dmem_ack(dmemAck), .dmem_rdata(dmemRdata),
    .out_valid(outValid), .RegWrite_next(regWriteNext), .UARTtoReg_next(uartToRegNext),
    .MemtoReg_next(memToRegNext), .Branch_next(branchNext), .read_data(readData),
    .register_data_next(registerDataNext), .alu_result_next(aluResultNext),
    .rdist_next(rdistNext), .inst_index_next(instIndexNext),
    .pc_next(pcNext), .pc1_next(pc1Next), .pc2_next(pc2Next), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one instruction for a single cycle and queue its expected write-back fields.
  task automatic applyStimulus(input logic wrEn, input logic stEn, input logic ldEn,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] data, input logic [31:0] addr,
                               input logic [4:0] dest, input logic [IW-1:0] pcBase,
                               input logic [31:0] expRead, input logic expMis);
    expect_t e;
    @(negedge clk);
    txnId++;
    inValid      = 1'b1;
    regWrite     = wrEn;
    memWrite     = stEn;
    memRead      = ldEn;
    memSize      = size;
    memUnsigned  = uns;
    registerData = data;
    aluResult    = addr;
    rdist        = dest;
    pc           = pcBase;
    pc1          = IW'(pcBase + 1);
    pc2          = IW'(pcBase + 2);
    instIndex    = 26'(txnId * 1000 + 7);
    memToReg     = 2'(txnId);
    branch       = 2'(txnId + 1);
    uartToReg    = txnId[0];
    e.aluResult  = addr;
    e.readData   = expRead;
    e.regData    = data;
    e.regWrite   = wrEn & ~expMis;
    e.uartToReg  = uartToReg;
    e.misalign   = expMis;
    e.memToReg   = memToReg;
    e.branch     = branch;
    e.rdist      = dest;
    e.instIndex  = instIndex;
    e.pc         = pc;
    e.pc1        = pc1;
    e.pc2        = pc2;
    scoreboard.push_back(e);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // Act as the data memory: hold ack low for a while, then acknowledge once.
  task automatic serveMem(input int lowCycles, input logic [31:0] rdata);
    for (int i = 0; i < lowCycles; i++) begin
      check("req_held", 32'(dmemReq), 32'd1);
      check("stall", 32'(inReady), 32'd0);
      @(negedge clk);
    end
    dmemAck   = 1'b1;
    dmemRdata = rdata;
    @(negedge clk);
    dmemAck   = 1'b0;
    dmemRdata = '0;
  endtask

  // Wait (bounded) for out_valid, pop the scoreboard and compare every field.
  task automatic checkOutput(input string tag);
    expect_t e;
    int waited = 0;
    while (outValid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, ".out_valid"}, 32'(outValid), 32'd1);
    check({tag, ".latency"}, 32'(waited), 32'd0);
    if (scoreboard.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = scoreboard.pop_front();
      check({tag, ".alu_result"}, aluResultNext, e.aluResult);
      check({tag, ".read_data"}, readData, e.readData);
      check({tag, ".register_data"}, registerDataNext, e.regData);
      check({tag, ".RegWrite"}, 32'(regWriteNext), 32'(e.regWrite));
      check({tag, ".UARTtoReg"}, 32'(uartToRegNext), 32'(e.uartToReg));
      check({tag, ".misalign"}, 32'(misalign), 32'(e.misalign));
      check({tag, ".MemtoReg"}, 32'(memToRegNext), 32'(e.memToReg));
      check({tag, ".Branch"}, 32'(branchNext), 32'(e.branch));
      check({tag, ".rdist"}, 32'(rdistNext), 32'(e.rdist));
      check({tag, ".inst_index"}, 32'(instIndexNext), 32'(e.instIndex));
      check({tag, ".pc"}, 32'(pcNext), 32'(e.pc));
      check({tag, ".pc1"}, 32'(pc1Next), 32'(e.pc1));
      check({tag, ".pc2"}, 32'(pc2Next), 32'(e.pc2));
      @(negedge clk);
      check({tag, ".pulse"}, 32'(outValid), 32'd0);
      check({tag, ".hold"}, aluResultNext, e.aluResult);
      check({tag, ".misalign_pulse"}, 32'(misalign), 32'd0);
    end
  endtask

  initial begin
    rstN = 1'b0; inValid = 1'b0; regWrite = 1'b0; memWrite = 1'b0; memRead = 1'b0;
    uartToReg = 1'b0; memToReg = '0; branch = '0; memSize = '0; memUnsigned = 1'b0;
    registerData = '0; aluResult = '0; rdist = '0; instIndex = '0;
    pc = '0; pc1 = '0; pc2 = '0; dmemAck = 1'b0; dmemRdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(inReady), 32'd0);
    check("rst.dmem_req", 32'(dmemReq), 32'd0);
    check("rst.out_valid", 32'(outValid), 32'd0);
    check("rst.read_data", readData, 32'd0);
    rstN = 1'b1;
    @(negedge clk);
    check("rel.in_ready", 32'(inReady), 32'd1);

    // ALU op: one-cycle latency, no memory request
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF,
                  5'b01010, 2'd0, 32'h0, 1'b0);
    check("alu.no_req", 32'(dmemReq), 32'd0);
    checkOutput("alu");

    // Store byte at 5 with slow ack
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1111_1155, 32'h0000_0005,
                  5'd3, 2'd1, 32'h0, 1'b0);
    check("sb.req", 32'(dmemReq), 32'd1);
    check("sb.we", 32'(dmemWe), 32'd1);
    check("sb.be", 32'(dmemBe), 32'h2);
    check("sb.wdata", dmemWdata, 32'h5555_5555);
    check("sb.addr", 32'(dmemAddr), 32'd1);
    serveMem(3, 32'h0);
    checkOutput("sb");

    // Store half at 6: upper lanes
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0000_0006,
                  5'd4, 2'd2, 32'h0, 1'b0);
    check("sh.be", 32'(dmemBe), 32'hC);
    check("sh.wdata", dmemWdata, 32'hABCD_ABCD);
    check("sh.addr", 32'(dmemAddr), 32'd1);
    serveMem(1, 32'h0);
    checkOutput("sh");

    // Load half signed / unsigned at 2 (minimum latency for the first)
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0, 32'h0000_0002,
                  5'd5, 2'd3, 32'hFFFF_80FF, 1'b0);
    check("lh.we", 32'(dmemWe), 32'd0);
    check("lh.addr", 32'(dmemAddr), 32'd0);
    serveMem(0, 32'h80FF_1234);
    checkOutput("lh");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h0, 32'h0000_0002,
                  5'd6, 2'd0, 32'h0000_80FF, 1'b0);
    serveMem(1, 32'h80FF_1234);
    checkOutput("lhu");

    // Load byte signed / unsigned at 1
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0000_0001,
                  5'd7, 2'd1, 32'hFFFF_FFF0, 1'b0);
    serveMem(2, 32'h0000_F000);
    checkOutput("lb");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0000_0001,
                  5'd8, 2'd2, 32'h0000_00F0, 1'b0);
    serveMem(0, 32'h0000_F000);
    checkOutput("lbu");

    // Word load at top word address
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_001C,
                  5'd9, 2'd3, 32'h1234_5678, 1'b0);
    check("lw.addr", 32'(dmemAddr), 32'd7);
    serveMem(1, 32'h1234_5678);
    checkOutput("lw");

    // MemRead and MemWrite together: a write, read_data forced to zero
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h1234_5678, 32'h0000_0008,
                  5'd10, 2'd0, 32'h0, 1'b0);
    check("rw.we", 32'(dmemWe), 32'd1);
    check("rw.be", 32'(dmemBe), 32'hF);
    check("rw.wdata", dmemWdata, 32'h1234_5678);
    check("rw.addr", 32'(dmemAddr), 32'd2);
    serveMem(0, 32'hDEAD_BEEF);
    checkOutput("rw");

    // Misaligned word load and misaligned half store
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h5555_5555,
                  5'd11, 2'd1, 32'h0, 1'b1);
    check("mis_lw.no_req", 32'(dmemReq), 32'd0);
    checkOutput("mis_lw");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'hCAFE_0000, 32'h0000_0003,
                  5'd12, 2'd2, 32'h0, 1'b1);
    check("mis_sh.no_req", 32'(dmemReq), 32'd0);
    checkOutput("mis_sh");

    // Reset while waiting: request dropped, transaction discarded
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_0004,
                  5'd13, 2'd3, 32'h0, 1'b0);
    void'(scoreboard.pop_back());
    check("rw_wait.req", 32'(dmemReq), 32'd1);
    rstN = 1'b0;
    #1;
    check("rw_rst.dmem_req", 32'(dmemReq), 32'd0);
    check("rw_rst.in_ready", 32'(inReady), 32'd0);
    check("rw_rst.alu_next", aluResultNext, 32'd0);
    check("rw_rst.rdist_next", 32'(rdistNext), 32'd0);
    check("rw_rst.pc1_next", 32'(pc1Next), 32'd0);
    check("rw_rst.inst_next", 32'(instIndexNext), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check("rw_rel.in_ready", 32'(inReady), 32'd1);
    @(negedge clk);
    dmemAck   = 1'b1;
    dmemRdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmemAck   = 1'b0;
    check("idle_ack.out_valid", 32'(outValid), 32'd0);
    check("idle_ack.dmem_req", 32'(dmemReq), 32'd0);
    check("idle_ack.read_data", readData, 32'd0);
    check("sb_empty", 32'(scoreboard.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
